// File: rtl/atpg_pattern_player_pkg.sv
// Shared types and constants for the ATPG pattern player: fill policy, FSM
// states and the MISR polynomial with its single-step helper.
package atpg_pattern_player_pkg;

    typedef enum logic [1:0] {
        FILL0     = 2'd0,
        FILL1     = 2'd1,
        FILL_ADJ  = 2'd2,
        FILL_HOLD = 2'd3
    } fill_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // x^16 + x^15 + x^13 + x^4 + 1, x^16 implied by the shift-out
    localparam logic [15:0] MISR_POLY = 16'hA011;

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ d;
    endfunction

endpackage

// File: rtl/atpg_pattern_player_if.sv
// Pattern-source handshake: one pattern (stimulus, care bits, expected
// response, compare mask) per valid/ready transfer.
interface atpg_pattern_player_if #(
    parameter int NINPUTS  = 5,
    parameter int NOUTPUTS = 2
);
    logic                pat_valid;
    logic                pat_ready;
    logic [NINPUTS-1:0]  pat_pi;
    logic [NINPUTS-1:0]  pat_care;
    logic [NOUTPUTS-1:0] pat_xpct;
    logic [NOUTPUTS-1:0] pat_mask;

    modport master (output pat_valid, pat_pi, pat_care, pat_xpct, pat_mask,
                    input  pat_ready);
    modport slave  (input  pat_valid, pat_pi, pat_care, pat_xpct, pat_mask,
                    output pat_ready);
endinterface

// File: rtl/atpg_pattern_player_fill.sv
// Combinational X-fill: resolves don't-care stimulus bits into the next
// core drive vector according to the selected fill policy.
module atpg_fill
    import atpg_pattern_player_pkg::*;
#(
    parameter int NINPUTS = 5
) (
    input  logic [NINPUTS-1:0] pi,
    input  logic [NINPUTS-1:0] care,
    input  fill_mode_e         mode,
    input  logic [NINPUTS-1:0] cur,
    output logic [NINPUTS-1:0] filled
);

    // near[i]: value of the closest care bit strictly below bit i (0 if none)
    logic [NINPUTS-1:0] near;
    assign near[0] = 1'b0;

    generate
        for (genvar i = 0; i < NINPUTS; i++) begin : g_bit
            if (i < NINPUTS - 1) begin : g_chain
                assign near[i+1] = care[i] ? pi[i] : near[i];
            end
            assign filled[i] = care[i]            ? pi[i]   :
                               (mode == FILL0)    ? 1'b0    :
                               (mode == FILL1)    ? 1'b1    :
                               (mode == FILL_ADJ) ? near[i] :
                                                    cur[i];
        end
    endgenerate

endmodule

// File: rtl/atpg_pattern_player.sv
// ATPG pattern player: accepts a pattern, drives the filled stimulus, strobes
// the core after CAPTURE_DLY edges and keeps pass/fail statistics.
// Optional MISR signature enabled by ATPG_PATTERN_PLAYER_MISR_EN.
module atpg_pattern_player
    import atpg_pattern_player_pkg::*;
#(
    parameter int NINPUTS     = 5,
    parameter int NOUTPUTS    = 2,
    parameter int CAPTURE_DLY = 4,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [1:0]          fill_mode,
    atpg_pattern_player_if.slave pat,
    output logic [NINPUTS-1:0]  dut_pi,
    input  logic [NOUTPUTS-1:0] dut_po,
    output logic                fail_valid,
    output logic [NOUTPUTS-1:0] fail_bits,
    output logic [CNT_W-1:0]    pat_count,
    output logic [CNT_W-1:0]    fail_count,
    output logic [CNT_W-1:0]    first_fail_idx,
    output logic                first_fail_vld,
    output logic [15:0]         signature,
    output logic                busy
);

    localparam int DW = (CAPTURE_DLY > 1) ? $clog2(CAPTURE_DLY) : 1;
    localparam logic [DW-1:0] DLY_LOAD = DW'(CAPTURE_DLY - 1);

    state_e              state, state_nxt;
    logic [DW-1:0]       dly_cnt;
    logic [NOUTPUTS-1:0] xpct_q, mask_q;
    logic [NOUTPUTS-1:0] mism;
    logic [NINPUTS-1:0]  pi_filled;
    logic                ready, accept, strobe;

    atpg_fill #(.NINPUTS(NINPUTS)) u_fill (
        .pi     (pat.pat_pi),
        .care   (pat.pat_care),
        .mode   (fill_mode_e'(fill_mode)),
        .cur    (dut_pi),
        .filled (pi_filled)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (pat.pat_valid)   state_nxt = WAIT;
            WAIT: if (dly_cnt == '0)   state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready  = (state == IDLE);
        busy   = (state == WAIT);
        accept = ready && pat.pat_valid;
        strobe = busy && (dly_cnt == '0);
    end

    assign pat.pat_ready = ready;
    assign mism          = (dut_po ^ xpct_q) & mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_cnt <= '0;
            xpct_q  <= '0;
            mask_q  <= '0;
            dut_pi  <= '0;
        end else if (accept) begin
            dly_cnt <= DLY_LOAD;
            xpct_q  <= pat.pat_xpct;
            mask_q  <= pat.pat_mask;
            dut_pi  <= pi_filled;
        end else if (busy && dly_cnt != '0) begin
            dly_cnt <= dly_cnt - 1'b1;
        end
    end

    // Strobe result is reported even when clear wins on the counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_valid <= 1'b0;
            fail_bits  <= '0;
        end else begin
            fail_valid <= strobe && (|mism);
            if (strobe) fail_bits <= mism;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_count      <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else if (clear) begin
            pat_count      <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else if (strobe) begin
            if (pat_count != '1) pat_count <= pat_count + 1'b1;
            if (|mism) begin
                if (fail_count != '1) fail_count <= fail_count + 1'b1;
                if (!first_fail_vld) begin
                    first_fail_idx <= pat_count;
                    first_fail_vld <= 1'b1;
                end
            end
        end
    end

`ifdef ATPG_PATTERN_PLAYER_MISR_EN
    logic [15:0] misr_q;
    logic [15:0] misr_in;

    assign misr_in = 16'(dut_po & mask_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         misr_q <= '0;
        else if (clear)  misr_q <= '0;
        else if (strobe) misr_q <= misr_step(misr_q, misr_in);
    end

    assign signature = misr_q;
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_atpg_pattern_player.sv
// Directed plus randomized bench for atpg_pattern_player, checked against a
// behavioural model of fill, compare, statistics and MISR.
module tb_atpg_pattern_player;

    localparam int NI  = 5;
    localparam int NO  = 2;
    localparam int DLY = 4;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst, clear;
    logic [1:0]    fill_mode;
    logic [NI-1:0] dut_pi;
    logic [NO-1:0] dut_po, fail_bits;
    logic          fail_valid, first_fail_vld, busy;
    logic [CW-1:0] pat_count, fail_count, first_fail_idx;
    logic [15:0]   signature;

    atpg_pattern_player_if #(.NINPUTS(NI), .NOUTPUTS(NO)) pif ();

    atpg_pattern_player #(
        .NINPUTS(NI), .NOUTPUTS(NO), .CAPTURE_DLY(DLY), .CNT_W(CW)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .fill_mode      (fill_mode),
        .pat            (pif),
        .dut_pi         (dut_pi),
        .dut_po         (dut_po),
        .fail_valid     (fail_valid),
        .fail_bits      (fail_bits),
        .pat_count      (pat_count),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .first_fail_vld (first_fail_vld),
        .signature      (signature),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // reference model state
    int            m_pat, m_fail, m_ffi;
    bit            m_ffv;
    int            m_sig;
    logic [NI-1:0] m_pi;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NI-1:0] fill_ref(input logic [NI-1:0] pi, input logic [NI-1:0] care,
                                               input int mode, input logic [NI-1:0] prev);
        logic [NI-1:0] r;
        for (int i = 0; i < NI; i++) begin
            if (care[i]) r[i] = pi[i];
            else if (mode == 0) r[i] = 1'b0;
            else if (mode == 1) r[i] = 1'b1;
            else if (mode == 3) r[i] = prev[i];
            else begin
                r[i] = 1'b0;
                for (int j = i - 1; j >= 0; j--)
                    if (care[j]) begin r[i] = pi[j]; break; end
            end
        end
        return r;
    endfunction

    // multiply by x modulo the MISR polynomial, then add the input word
    function automatic int misr_ref(input int s, input int d);
        int t;
        t = s * 2;
        if (t >= 65536) t = t ^ 'h1A011;
        return t ^ d;
    endfunction

    task automatic model_reset();
        m_pat = 0; m_fail = 0; m_ffi = 0; m_ffv = 0; m_sig = 0; m_pi = '0;
    endtask

    task automatic check_stats(input string pfx);
        chk({pfx, "_pat_count"},  pat_count,      m_pat);
        chk({pfx, "_fail_count"}, fail_count,     m_fail);
        chk({pfx, "_ffi"},        first_fail_idx, m_ffi);
        chk({pfx, "_ffv"},        first_fail_vld, m_ffv);
        chk({pfx, "_signature"},  signature,      m_sig);
    endtask

    task automatic apply(input logic [NI-1:0] pi, input logic [NI-1:0] care,
                         input logic [NO-1:0] xpct, input logic [NO-1:0] mask,
                         input logic [NO-1:0] po, input int mode, input bit do_clr,
                         output logic [NI-1:0] got_pi);
        int            guard;
        logic [NI-1:0] exp_pi;
        logic [NO-1:0] mism;
        guard = 0;
        while (pif.pat_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        chk("ready_before_accept", pif.pat_ready, 1);
        pif.pat_valid = 1'b1; pif.pat_pi = pi; pif.pat_care = care;
        pif.pat_xpct = xpct; pif.pat_mask = mask;
        fill_mode = 2'(mode); dut_po = po;
        @(posedge clk); #1;
        n_vec++;
        exp_pi = fill_ref(pi, care, mode, m_pi);
        m_pi   = exp_pi;
        got_pi = dut_pi;
        chk("dut_pi_after_accept", dut_pi, exp_pi);
        chk("busy_in_wait", busy, 1);
        chk("ready_low_in_wait", pif.pat_ready, 0);
        // junk on the pattern port while waiting must be ignored
        for (int k = 1; k <= DLY; k++) begin
            if (k < DLY) begin
                pif.pat_valid = 1'b1; pif.pat_pi = NI'($urandom); pif.pat_care = NI'($urandom);
                pif.pat_xpct = NO'($urandom); pif.pat_mask = NO'($urandom);
                fill_mode = 2'($urandom);
            end else begin
                pif.pat_valid = 1'b0;
                if (do_clr) clear = 1'b1;
            end
            @(posedge clk); #1;
            clear = 1'b0;
            if (k < DLY) chk("no_early_strobe", fail_valid, 0);
        end
        mism = (po ^ xpct) & mask;
        if (do_clr) begin
            m_pat = 0; m_fail = 0; m_ffi = 0; m_ffv = 0; m_sig = 0;
        end else begin
            if (mism != 0) begin
                if (m_fail < 65535) m_fail++;
                if (!m_ffv) begin m_ffi = m_pat; m_ffv = 1; end
            end
            if (m_pat < 65535) m_pat++;
`ifdef ATPG_PATTERN_PLAYER_MISR_EN
            m_sig = misr_ref(m_sig, int'(po & mask));
`endif
        end
        chk("fail_valid_at_strobe", fail_valid, (mism != 0));
        chk("fail_bits", fail_bits, mism);
        chk("dut_pi_held", dut_pi, exp_pi);
        chk("ready_after_strobe", pif.pat_ready, 1);
        chk("busy_after_strobe", busy, 0);
        check_stats("strobe");
        @(posedge clk); #1;
        chk("fail_valid_one_cycle", fail_valid, 0);
    endtask

    logic [NI-1:0] got;
    logic [NI-1:0] fill_exp [4];

    initial begin
        fill_exp[0] = 5'b10100; fill_exp[1] = 5'b11110;
        fill_exp[2] = 5'b11100; fill_exp[3] = 5'b11110;
        rst = 1'b1; clear = 1'b0; fill_mode = 2'd0; dut_po = '0;
        pif.pat_valid = 1'b0; pif.pat_pi = '0; pif.pat_care = '0;
        pif.pat_xpct = '0; pif.pat_mask = '0;
        model_reset();
        #12;
        chk("rst_ready", pif.pat_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dut_pi", dut_pi, 0);
        chk("rst_fail_valid", fail_valid, 0);
        chk("rst_fail_bits", fail_bits, 0);
        check_stats("rst");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // basic pass, then a second pass pattern to exercise the MISR from reset
        apply(5'b11101, 5'b11111, 2'b10, 2'b11, 2'b10, 0, 0, got);
        chk("basic_dut_pi", got, 5'b11101);
        chk("basic_pat_count", pat_count, 1);
        apply(5'b00110, 5'b11111, 2'b01, 2'b11, 2'b01, 0, 0, got);

        // standalone clear in IDLE
        clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
        m_pat = 0; m_fail = 0; m_ffi = 0; m_ffv = 0; m_sig = 0;
        check_stats("clear_idle");

        // fail / first-fail
        apply(5'b00001, 5'b11111, 2'b00, 2'b11, 2'b00, 0, 0, got);
        apply(5'b00010, 5'b11111, 2'b00, 2'b11, 2'b01, 0, 0, got);
        chk("ff_fail_bits", fail_bits, 2'b01);
        chk("ff_idx", first_fail_idx, 1);
        chk("ff_count", fail_count, 1);
        apply(5'b00011, 5'b11111, 2'b00, 2'b11, 2'b10, 0, 0, got);
        chk("ff_idx_sticky", first_fail_idx, 1);
        chk("ff_count2", fail_count, 2);

        // masking: upper expected bit is don't-care
        apply(5'b01000, 5'b11111, 2'b01, 2'b01, 2'b11, 0, 0, got);
        chk("mask_no_fail_bits", fail_bits, 0);

        // fill modes against the tabulated expectations
        for (int m = 0; m < 4; m++) begin
            apply(5'b01010, 5'b11111, 2'b00, 2'b00, 2'b00, 0, 0, got);
            apply(5'b10100, 5'b10101, 2'b00, 2'b00, 2'b00, m, 0, got);
            chk("fill_mode_table", got, fill_exp[m]);
        end

        // randomized patterns
        for (int r = 0; r < 40; r++) begin
            apply(NI'($urandom), NI'($urandom), NO'($urandom), NO'($urandom), NO'($urandom),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), got);
        end

        // clear coinciding with a failing strobe
        apply(5'b11111, 5'b11111, 2'b00, 2'b11, 2'b11, 0, 1, got);
        chk("clr_strobe_fail_count", fail_count, 0);
        chk("clr_strobe_fail_bits", fail_bits, 2'b11);

        // reset in the middle of WAIT drops the pattern
        pif.pat_valid = 1'b1; pif.pat_pi = 5'b10101; pif.pat_care = 5'b11111;
        pif.pat_xpct = 2'b00; pif.pat_mask = 2'b11; dut_po = 2'b11; fill_mode = 2'd0;
        @(posedge clk); #1; pif.pat_valid = 1'b0; n_vec++;
        chk("pre_rst_busy", busy, 1);
        @(posedge clk); #1;
        rst = 1'b1; #2;
        model_reset();
        chk("midrst_ready", pif.pat_ready, 1);
        chk("midrst_dut_pi", dut_pi, 0);
        check_stats("midrst");
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < DLY + 2; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_fail_valid", fail_valid, 0);
        end
        chk("midrst_pat_count", pat_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
